pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the five-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in a scoreboard. Detects RAW hazards from the instruction in ID.
- Emits stall, flush and bubble controls to the PC and the if_id, id_ex, ex_mem and mem_wb registers.
- Also sequences branch redirects and the ebreak drain/halt.

Parameters:
- NREG, 32, architectural register count; x0 is never a hazard source.
- RIDX_W, 5, register index width.
- DRAIN_CYC, 3, cycles waited after ebreak enters EX before halt (EX→WB retirement).

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source 1 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2  in  5  ID source 2 index.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  5  ID destination index.
- id_rd_wen  in  1  instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_ebreak  in  1  ID instruction is ebreak.
- ex_redirect  in  1  EX resolved a taken branch or jump (pc_sel).
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold if_id.
- ifid_flush  out  1  clear if_id valid.
- idex_bubble  out  1  load id_ex with a NOP (valid=0).
- exmem_valid  out  1  valid bit tracked for the EX instruction.
- memwb_valid  out  1  valid bit tracked for the MEM instruction.
- halted  out  1  core halted after ebreak.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard: three slots sb_ex, sb_mem, sb_wb. Each holds {valid, rd, is_load}.
  - Every non-halted cycle the slots shift ex→mem→wb.
  - sb_ex loads the ID instruction's {id_valid&id_rd_wen&(id_rd!=0), id_rd, id_is_load}, or zero when a bubble or flush is inserted.
- hazard (combinational): id_valid & (rsX_used & rsX!=0 & rsX matches a valid slot in the set defined by the Optional Feature), for X in 1,2.
- Outputs:
  - pc_stall = ifid_stall = hazard & ~ex_redirect, or state != RUN.
  - idex_bubble = hazard | ex_redirect | state != RUN.
  - ifid_flush = ex_redirect.
- Redirect has priority over stall in the same cycle. Both if_id and id_ex are squashed; the PC is not held.
- Redirect during DRAIN: the ebreak is already past ID, so the flush still applies and the drain count continues.
- exmem_valid / memwb_valid are shifted valid bits mirroring pipeline occupancy; both are registered.
- FSM states: RUN, DRAIN, HALT.
  - RUN→DRAIN: id_ebreak & id_valid & ~hazard & ~ex_redirect. The ebreak advances into EX, and the drain counter loads DRAIN_CYC.
  - DRAIN: counter decrements each cycle. Fetch is frozen and bubbles are inserted. At counter==1 → HALT.
  - HALT: all stalls asserted, halted=1, scoreboard frozen. Only sys_rst exits.
- stall_cnt increments by 1 on every cycle with hazard & ~ex_redirect in RUN, and saturates at 0xFFFF.
- Reset (including mid-stall or mid-drain):
  - all slots invalid; state=RUN; counter=0; stall_cnt=0; halted=0; exmem_valid=memwb_valid=0.
  - Combinational outputs follow directly from the cleared state.
- Registered outputs update on the edge after their cause. Combinational controls are valid in the same cycle as the ID inputs.

Optional Feature:
- Macro: PIPE_FORWARD_EN.
- Defined: forwarding exists in EX. Hazard compares only against sb_ex with is_load=1, giving a one-cycle load-use stall. ALU results never stall.
- Undefined: no forwarding, and the regfile is not write-through. Hazard compares against sb_ex, sb_mem and sb_wb, so stalls last up to 3 cycles until the producer leaves WB.

Test Plan:
- No forwarding: add x5 in ID, then sub x6,x5,x7 → pc_stall high for exactly 3 cycles, then 3 NOP bubbles; stall_cnt=3.
- PIPE_FORWARD_EN: ld x5 then add x6,x5,x1 → exactly 1 stall cycle. Replacing ld with add → 0 stall cycles.
- Hazard and ex_redirect asserted in the same cycle → ifid_flush=1, idex_bubble=1, pc_stall=0. Next cycle the scoreboard sb_ex is invalid.
- rs1=0 with a producer writing x0 → no stall; the producer's slot never becomes valid.
- ebreak reaches ID with an empty pipeline → DRAIN for 3 cycles. halted=1 on the 4th edge and stays 1 for 10 cycles with all stalls high.
- Assert sys_rst during DRAIN and during a 2nd stall cycle → next cycle state=RUN, halted=0, stall_cnt=0, no stall outputs.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV64 pipeline: RAW scoreboard, redirect squash, ebreak drain/halt.
// Build option: define PIPE_FORWARD_EN when EX forwarding exists (only load-use then stalls).
module pipe_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int RIDX_W    = 5,
  parameter int DRAIN_CYC = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_rd_wen,
  input  logic              id_is_load,
  input  logic              id_ebreak,
  input  logic              ex_redirect,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_valid,
  output logic              memwb_valid,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  typedef struct packed {
    logic              vld;
    logic [RIDX_W-1:0] rd;
    logic              is_load;
  } slot_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  slot_t            sb_ex, sb_mem, sb_wb;
  slot_t            sb_in;
  logic             rs1_hit, rs2_hit, hazard, not_run;

  function automatic logic slot_match(slot_t s, logic [RIDX_W-1:0] rs);
    return s.vld && (s.rd == rs);
  endfunction

  // x0 and indices beyond the architectural file never create a dependency
  function automatic logic src_live(logic [RIDX_W-1:0] rs, logic used);
    return used && (rs != '0) && (int'(rs) < NREG);
  endfunction

`ifdef PIPE_FORWARD_EN
  assign rs1_hit = src_live(id_rs1, id_rs1_used) && slot_match(sb_ex, id_rs1) && sb_ex.is_load;
  assign rs2_hit = src_live(id_rs2, id_rs2_used) && slot_match(sb_ex, id_rs2) && sb_ex.is_load;
  logic unused_slots;
  assign unused_slots = ^{sb_mem, sb_wb};
`else
  assign rs1_hit = src_live(id_rs1, id_rs1_used) &&
                   (slot_match(sb_ex, id_rs1) || slot_match(sb_mem, id_rs1) || slot_match(sb_wb, id_rs1));
  assign rs2_hit = src_live(id_rs2, id_rs2_used) &&
                   (slot_match(sb_ex, id_rs2) || slot_match(sb_mem, id_rs2) || slot_match(sb_wb, id_rs2));
  logic unused_load_bits;
  assign unused_load_bits = ^{sb_ex.is_load, sb_mem.is_load, sb_wb.is_load};
`endif

  assign hazard      = id_valid && (rs1_hit || rs2_hit);
  assign not_run     = (state != RUN);
  assign pc_stall    = (hazard && !ex_redirect) || not_run;
  assign ifid_stall  = pc_stall;
  assign idex_bubble = hazard || ex_redirect || not_run;
  assign ifid_flush  = ex_redirect;

  always_comb begin
    sb_in         = '0;
    sb_in.vld     = id_valid && id_rd_wen && (id_rd != '0);
    sb_in.rd      = id_rd;
    sb_in.is_load = id_is_load;
    if (idex_bubble) sb_in = '0;
  end

  // ID -> EX boundary: scoreboard and occupancy shift, FSM and stall counter advance
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= RUN;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      stall_cnt   <= '0;
      sb_ex       <= '0;
      sb_mem      <= '0;
      sb_wb       <= '0;
      exmem_valid <= 1'b0;
      memwb_valid <= 1'b0;
    end else begin
      if (state != HALT) begin
        sb_wb       <= sb_mem;
        sb_mem      <= sb_ex;
        sb_ex       <= sb_in;
        memwb_valid <= exmem_valid;
        exmem_valid <= id_valid && !idex_bubble;
      end
      case (state)
        RUN: begin
          if (hazard && !ex_redirect && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
          if (id_ebreak && id_valid && !hazard && !ex_redirect) begin
            state     <= DRAIN;
            drain_cnt <= CNT_W'(DRAIN_CYC);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt <= CNT_W'(1)) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        default: halted <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a queue-based pipeline occupancy model.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DRAIN_CYC = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rd_wen = 1'b0, id_is_load = 1'b0, id_ebreak = 1'b0, ex_redirect = 1'b0;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic        exmem_valid, memwb_valid, halted;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(.NREG(32), .RIDX_W(5), .DRAIN_CYC(DRAIN_CYC)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .id_is_load(id_is_load), .id_ebreak(id_ebreak), .ex_redirect(ex_redirect),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_valid(exmem_valid), .memwb_valid(memwb_valid),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: instructions downstream of ID, youngest first (EX, MEM, WB).
  typedef struct {
    bit       v;
    bit       w;
    bit [4:0] rd;
    bit       ld;
  } ent_t;

  ent_t pl[$];
  int   cnum;
  int   ebk_cyc;
  int   m_scnt;

  function automatic void m_reset();
    ent_t z;
    z = '{v: 1'b0, w: 1'b0, rd: 5'd0, ld: 1'b0};
    pl = {z, z, z};
    ebk_cyc = -1;
    m_scnt = 0;
  endfunction

  // A source waits while any not-yet-retired writer of it is visible (only an EX load with forwarding).
  function automatic bit m_dep(input bit [4:0] rs, input bit used);
    int depth;
    if (!used || rs == 5'd0) return 1'b0;
    depth = FWD ? 1 : 3;
    for (int k = 0; k < depth; k++)
      if (pl[k].w && pl[k].rd == rs && (!FWD || pl[k].ld)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input bit rst, input bit v, input bit [4:0] r1, input bit u1,
                     input bit [4:0] r2, input bit u2, input bit [4:0] rd, input bit wen,
                     input bit ld, input bit eb, input bit redir, output bit stalled);
    bit running, halt_e, haz, bub;
    ent_t e;
    @(negedge sys_clk);
    sys_rst = rst; id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_ebreak = eb; ex_redirect = redir;
    #1;
    running = (ebk_cyc < 0) || (cnum <= ebk_cyc);
    halt_e  = (ebk_cyc >= 0) && (cnum >= ebk_cyc + 1 + DRAIN_CYC);
    haz     = v && (m_dep(r1, u1) || m_dep(r2, u2));
    bub     = haz || redir || !running;
    check("pc_stall",    pc_stall,    (haz && !redir) || !running);
    check("ifid_stall",  ifid_stall,  (haz && !redir) || !running);
    check("ifid_flush",  ifid_flush,  redir);
    check("idex_bubble", idex_bubble, bub);
    check("halted",      halted,      halt_e);
    check("stall_cnt",   stall_cnt,   m_scnt);
    check("exmem_valid", exmem_valid, pl[0].v);
    check("memwb_valid", memwb_valid, pl[1].v);
    stalled = pc_stall;
    if (rst) begin
      m_reset();
    end else begin
      if (running && haz && !redir && m_scnt < 65535) m_scnt++;
      if (running && eb && v && !haz && !redir) ebk_cyc = cnum;
      if (!halt_e) begin
        e = '{v: v && !bub, w: v && !bub && wen && rd != 5'd0, rd: rd, ld: !bub && ld};
        pl.push_front(e);
        void'(pl.pop_back());
      end
    end
    cnum++;
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  task automatic do_reset();
    bit s;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  // Hold a consumer of x5 in ID after a producer; returns how many cycles it was stalled.
  task automatic raw_seq(input bit prod_ld, output int nstall);
    bit s;
    nstall = 0;
    cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, prod_ld, 0, 0, s);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0, s);
      if (!s) break;
      nstall++;
    end
  endtask

  initial begin
    bit s;
    int n;
    int halt_seen;
    int halt_run;
    cnum = 0;
    repeat (2) @(posedge sys_clk);
    m_reset();

    // RAW on an ALU producer
    raw_seq(1'b0, n);
    check("alu_raw_stalls", n, FWD ? 0 : 3);
    idle(4);
    check("alu_raw_stall_cnt", stall_cnt, FWD ? 0 : 3);

    // load-use
    do_reset();
    raw_seq(1'b1, n);
    check("load_use_stalls", n, FWD ? 1 : 3);
    idle(4);

    // hazard coincident with a redirect, then the same consumer again
    do_reset();
    cyc(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, s);
    cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 1, s);
    check("redir_no_pc_stall", s, 1'b0);
    cyc(0, 1, 5'd6, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, s);
    check("redir_squashed_slot", s, 1'b0);
    idle(4);

    // producer writing x0 followed by a reader of x0
    do_reset();
    cyc(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0, s);
    cyc(0, 1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0, 0, s);
    check("x0_no_stall", s, 1'b0);
    idle(3);

    // ebreak with an empty pipeline
    do_reset();
    idle(3);
    cyc(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, s);
    halt_seen = 0;
    halt_run = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, (k == 1), s);
      if (halted && halt_seen == 0) halt_seen = k + 1;
      if (halted) halt_run++;
    end
    check("halt_edge", halt_seen, DRAIN_CYC + 1);
    check("halt_hold", halt_run, 14 - DRAIN_CYC);

    // reset in the middle of a drain
    do_reset();
    cyc(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, s);
    idle(2);
    do_reset();
    idle(1);
    check("rst_drain_stall_cnt", stall_cnt, 16'd0);

    // reset on the second stall cycle
    cyc(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, s);
    cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, s);
    cyc(1, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, s);
    cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, s);
    check("rst_stall_cleared", s, 1'b0);

    // randomized traffic
    halt_run = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 63) == 0) || (halt_run > 12);
      cyc(rst, ($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 4)), 1'($urandom),
          5'($urandom_range(0, 4)), 1'($urandom),
          5'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 11) == 0), s);
      halt_run = halted ? halt_run + 1 : 0;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
